// File: rtl/simple_mem_responder_if.sv
// rtl/simple_mem_responder_if.sv - access bus between an initiator and simple_mem_responder
// Purpose : groups the request/response signals of the small memory responder.
// Signals : addr, wr_en, rd_en, wdata   - request, driven by the initiator (master)
//           rdata, rd_valid             - registered read response (slave)
//           wr_cnt, rd_cnt              - saturating access counters (slave)
interface simple_mem_responder_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) ();
   logic [ADDR_W-1:0] addr;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rd_valid;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  rd_cnt;

   modport master (
      output addr, wr_en, rd_en, wdata,
      input  rdata, rd_valid, wr_cnt, rd_cnt
   );

   modport slave (
      input  addr, wr_en, rd_en, wdata,
      output rdata, rd_valid, wr_cnt, rd_cnt
   );
endinterface

// File: rtl/simple_mem_responder.sv
// rtl/simple_mem_responder.sv - small register-file memory with registered reads and access counters
// Purpose : 2**ADDR_W x DATA_W storage; writes take effect on the sampling edge, reads
//           return data one cycle later with a one-cycle rd_valid strobe; wr_cnt/rd_cnt
//           count accepted accesses and saturate at all-ones.
// Ports   : clk  - single clock, everything on posedge
//           rst  - synchronous active-low reset (0 = reset), clears storage, outputs, counters
//           bus  - simple_mem_responder_if.slave (addr/wr_en/rd_en/wdata in,
//                  rdata/rd_valid/wr_cnt/rd_cnt out)
// Config  : SIMPLE_MEM_RD_FWD_EN defined   -> a same-edge write+read returns the new wdata
//           SIMPLE_MEM_RD_FWD_EN undefined -> a same-edge write+read returns the old content
module simple_mem_responder #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input logic                    clk,
   input logic                    rst,
   simple_mem_responder_if.slave  bus
);

   localparam int             DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rdata_q,    rdata_d;
   logic              rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0]  wr_cnt_q,   wr_cnt_d;
   logic [CNT_W-1:0]  rd_cnt_q,   rd_cnt_d;

   always_comb begin
      mem_d      = mem_q;
      rdata_d    = rdata_q;     // rdata holds between reads
      rd_valid_d = 1'b0;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;

      if (bus.wr_en) begin
         mem_d[bus.addr] = bus.wdata;
         if (wr_cnt_q != CNT_MAX) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end

      if (bus.rd_en) begin
         rd_valid_d = 1'b1;
`ifdef SIMPLE_MEM_RD_FWD_EN
         // write-first: bypass the array so a colliding read sees the new data
         rdata_d = bus.wr_en ? bus.wdata : mem_q[bus.addr];
`else
         // read-first: the array value before this edge's write
         rdata_d = mem_q[bus.addr];
`endif
         if (rd_cnt_q != CNT_MAX) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
   end

   // Reset wins over any access on the same edge, including dropping a pending read strobe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_q      <= '{default: '0};
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
      end else begin
         mem_q      <= mem_d;
         rdata_q    <= rdata_d;
         rd_valid_q <= rd_valid_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.wr_cnt   = wr_cnt_q;
   assign bus.rd_cnt   = rd_cnt_q;

endmodule

// File: tb/tb_simple_mem_responder.sv
// tb/tb_simple_mem_responder.sv - directed self-checking bench for simple_mem_responder
// Purpose : linear sequence of directed steps with hand-computed expectations; inputs
//           change 1 ns after a rising edge, outputs are sampled 1 ns after the next one.
// Config  : collision expectation follows SIMPLE_MEM_RD_FWD_EN.
module tb_simple_mem_responder;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   simple_mem_responder_if #(.ADDR_W(2), .DATA_W(8), .CNT_W(8)) bus ();

   simple_mem_responder #(.ADDR_W(2), .DATA_W(8), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [7:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b0;
      step();
   endtask

   task automatic do_read(input logic [1:0] a);
      bus.addr  = a;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1;
      step();
   endtask

   logic [7:0] coll_exp;

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      bus.addr  = '0;
      bus.wdata = '0;
      idle();
      #1;
      step();
      step();

      // reset state
      chk("reset_rdata",    32'(bus.rdata),    32'h00);
      chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
      chk("reset_wr_cnt",   32'(bus.wr_cnt),   32'h00);
      chk("reset_rd_cnt",   32'(bus.rd_cnt),   32'h00);

      // back-to-back reads of every entry right after reset release
      rst = 1'b1;
      for (int a = 0; a < 4; a++) begin
         logic [1:0] aa;
         aa = a[1:0];
         do_read(aa);
         chk($sformatf("init_rd_valid_a%0d", a), 32'(bus.rd_valid), 32'h1);
         chk($sformatf("init_rdata_a%0d", a),    32'(bus.rdata),    32'h00);
      end
      chk("init_rd_cnt", 32'(bus.rd_cnt), 32'd4);

      // fresh reset, then write 0xA5 to addr 2 and read it back
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
      do_write(2'd2, 8'hA5);
      chk("wr_rd_valid_low", 32'(bus.rd_valid), 32'h0);
      do_read(2'd2);
      chk("wr_rdata",    32'(bus.rdata),    32'hA5);
      chk("wr_rd_valid", 32'(bus.rd_valid), 32'h1);
      chk("wr_wr_cnt",   32'(bus.wr_cnt),   32'd1);
      chk("wr_rd_cnt",   32'(bus.rd_cnt),   32'd1);

      // collision at addr 1: old 0x11, new 0x22
      do_write(2'd1, 8'h11);
      bus.addr  = 2'd1;
      bus.wdata = 8'h22;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      step();
`ifdef SIMPLE_MEM_RD_FWD_EN
      coll_exp = 8'h22;
`else
      coll_exp = 8'h11;
`endif
      chk("coll_rdata",    32'(bus.rdata),    32'(coll_exp));
      chk("coll_rd_valid", 32'(bus.rd_valid), 32'h1);
      chk("coll_wr_cnt",   32'(bus.wr_cnt),   32'd3);
      chk("coll_rd_cnt",   32'(bus.rd_cnt),   32'd2);
      do_read(2'd1);
      chk("coll_mem1",     32'(bus.rdata),    32'h22);
      chk("coll_rd_cnt2",  32'(bus.rd_cnt),   32'd3);

      // idle cycle after a read of 0x5A
      do_write(2'd3, 8'h5A);
      do_read(2'd3);
      chk("hold_rdata_rd",  32'(bus.rdata),    32'h5A);
      idle();
      step();
      chk("hold_rd_valid",  32'(bus.rd_valid), 32'h0);
      chk("hold_rdata",     32'(bus.rdata),    32'h5A);

      // 300 consecutive writes saturate wr_cnt; rd_cnt untouched (4 reads so far)
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bus.addr  = i[1:0];
         bus.wdata = i[7:0];
         step();
      end
      chk("sat_wr_cnt", 32'(bus.wr_cnt), 32'd255);
      chk("sat_rd_cnt", 32'(bus.rd_cnt), 32'd4);
      do_write(2'd0, 8'h77);
      chk("sat_wr_cnt_hold", 32'(bus.wr_cnt), 32'd255);
      // last loop write hit addr 3 with 299 & 0xFF = 0x2B
      do_read(2'd3);
      chk("sat_mem3", 32'(bus.rdata), 32'h2B);

      // read at cycle N, reset at N+1 with requests still asserted
      do_read(2'd0);
      chk("pre_rst_valid", 32'(bus.rd_valid), 32'h1);
      chk("pre_rst_rdata", 32'(bus.rdata),    32'h77);
      rst       = 1'b0;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      bus.wdata = 8'hEE;
      step();
      chk("rst_drop_valid", 32'(bus.rd_valid), 32'h0);
      chk("rst_drop_rdata", 32'(bus.rdata),    32'h00);
      chk("rst_wr_cnt",     32'(bus.wr_cnt),   32'h00);
      chk("rst_rd_cnt",     32'(bus.rd_cnt),   32'h00);
      step();
      chk("rst_hold_wr_cnt", 32'(bus.wr_cnt), 32'h00);
      chk("rst_hold_valid",  32'(bus.rd_valid), 32'h0);
      rst = 1'b1;
      for (int a = 0; a < 4; a++) begin
         logic [1:0] aa;
         aa = a[1:0];
         do_read(aa);
         chk($sformatf("post_rst_mem_a%0d", a), 32'(bus.rdata), 32'h00);
      end
      chk("post_rst_wr_cnt", 32'(bus.wr_cnt), 32'd0);
      chk("post_rst_rd_cnt", 32'(bus.rd_cnt), 32'd4);

      idle();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
